mem_access: RTL and testbench



---
 rtl/mips_pkg.sv | 21 ++
 rtl/dmem_fsm.sv | 42 ++++
 rtl/mem_access.sv | 95 +++++++++
 tb/tb_mem_access.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and control-bit indices for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Bit positions inside the m_MEM / wb_MEM control bundles
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

endpackage
`default_nettype wire

// File: rtl/dmem_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dmem_fsm
// Description : Request/stall sequencer for the variable-latency data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_fsm
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_go,
    input  logic i_ack,
    output logic o_req,
    output logic o_stall,
    output logic o_complete
);

    mem_state_t r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_go && !i_ack) r_state <= BUSY;
                BUSY:    if (i_ack)          r_state <= IDLE;
                default:                     r_state <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so the bus request drops the instant reset asserts,
    // even if the frozen upstream register still presents an access.
    always_comb begin
        o_req      = rst_n & ((r_state == BUSY) | i_go);
        o_stall    = o_req & ~i_ack;
        o_complete = o_req & i_ack;
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MIPS MEM stage - data-memory access and MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] res_mem,
    input  logic [DATA_W-1:0] write_data_mem,
    input  logic [4:0]        write_register_mem,
    input  logic [2:0]        m_MEM,
    input  logic [1:0]        wb_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              addr_err,
    output logic [1:0]        wb_WB,
    output logic [4:0]        rd_WB,
    output logic [DATA_W-1:0] read_data_wb,
    output logic [ADDR_W-1:0] alu_res_wb
);

    logic       w_access;
    logic       w_misalign;
    logic       w_go;
    logic       w_is_store;
    logic       w_is_load;
    logic       w_complete;
    logic [1:0] w_wb_eff;
    logic       w_unused_branch;

    assign w_unused_branch = m_MEM[2];

    always_comb begin
        w_access   = m_MEM[M_READ] | m_MEM[M_WRITE];
        w_misalign = w_access & (res_mem[1:0] != 2'b00);
        w_go       = w_access & ~w_misalign;
        w_is_store = m_MEM[M_WRITE];
        w_is_load  = m_MEM[M_READ] & ~m_MEM[M_WRITE];
        w_wb_eff   = wb_MEM;
        // Read+write together behaves as a store, which never writes a register
        if (m_MEM[M_READ] && m_MEM[M_WRITE])
            w_wb_eff[WB_REGWRITE] = 1'b0;
        if (w_misalign)
            w_wb_eff = 2'b00;
    end

    dmem_fsm u_dmem_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_go       (w_go),
        .i_ack      (dmem_ack),
        .o_req      (dmem_req),
        .o_stall    (stall),
        .o_complete (w_complete)
    );

    assign dmem_we    = w_is_store;
    assign dmem_addr  = res_mem;
    assign dmem_wdata = write_data_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_WB        <= 2'b00;
            rd_WB        <= 5'd0;
            read_data_wb <= '0;
            alu_res_wb   <= '0;
            addr_err     <= 1'b0;
        end else begin
            addr_err <= w_misalign & ~stall;
            if (stall) begin
                wb_WB <= 2'b00;
            end else begin
                wb_WB      <= w_wb_eff;
                rd_WB      <= write_register_mem;
                alu_res_wb <= res_mem;
                if (w_complete && w_is_load)
                    read_data_wb <= dmem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Randomised self-checking bench for mem_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic [31:0] res_mem;
    logic [31:0] write_data_mem;
    logic [4:0]  write_register_mem;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        addr_err;
    logic [1:0]  wb_WB;
    logic [4:0]  rd_WB;
    logic [31:0] read_data_wb;
    logic [31:0] alu_res_wb;

    int total = 0;
    int bad   = 0;

    // Reference MEM/WB contents
    logic [1:0]  exp_wb;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] exp_alu;
    logic        exp_err;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .res_mem            (res_mem),
        .write_data_mem     (write_data_mem),
        .write_register_mem (write_register_mem),
        .m_MEM              (m_MEM),
        .wb_MEM             (wb_MEM),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .stall              (stall),
        .addr_err           (addr_err),
        .wb_WB              (wb_WB),
        .rd_WB              (rd_WB),
        .read_data_wb       (read_data_wb),
        .alu_res_wb         (alu_res_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wb_regs(input string tag);
        check({tag, " wb_WB"},        {30'd0, wb_WB},  {30'd0, exp_wb});
        check({tag, " rd_WB"},        {27'd0, rd_WB},  {27'd0, exp_rd});
        check({tag, " read_data_wb"}, read_data_wb,    exp_data);
        check({tag, " alu_res_wb"},   alu_res_wb,      exp_alu);
        check({tag, " addr_err"},     {31'd0, addr_err}, {31'd0, exp_err});
    endtask

    // One instruction held in EX/MEM until the stage lets it go. The memory
    // acknowledges on cycle 'lat' of the request; with no request the ack
    // line carries noise that must be ignored.
    task automatic run_instr(input logic [31:0] res, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [2:0] m,
                             input logic [1:0] wb, input int lat,
                             input logic [31:0] rdat);
        logic       acc, mis, go, st, ld, stalled;
        logic [1:0] wb_eff;
        int         last;
        acc    = m[1] | m[0];
        mis    = acc && (res[1:0] != 2'b00);
        go     = acc && !mis;
        st     = m[0];
        ld     = m[1] && !m[0];
        wb_eff = (m[1] && m[0]) ? {1'b0, wb[0]} : wb;
        if (mis) wb_eff = 2'b00;
        last   = go ? lat : 0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            res_mem            = res;
            write_data_mem     = wd;
            write_register_mem = rd;
            m_MEM              = m;
            wb_MEM             = wb;
            dmem_ack           = go ? (k == lat) : 1'($urandom_range(0, 1));
            dmem_rdata         = (go && k == lat) ? rdat : $urandom;
            #1;
            stalled = go && (k < lat);
            check("req",   {31'd0, dmem_req}, {31'd0, go});
            check("stall", {31'd0, stall},    {31'd0, stalled});
            if (go) begin
                check("addr",  dmem_addr,         res);
                check("we",    {31'd0, dmem_we},  {31'd0, st});
                check("wdata", dmem_wdata,        wd);
            end
            @(posedge clk);
            #1;
            if (stalled) begin
                exp_wb = 2'b00;
            end else begin
                exp_wb  = wb_eff;
                exp_rd  = rd;
                exp_alu = res;
                if (go && ld) exp_data = rdat;
            end
            exp_err = mis && !stalled;
            check_wb_regs("mewb");
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        res_mem            = '0;
        write_data_mem     = '0;
        write_register_mem = '0;
        m_MEM              = 3'b000;
        wb_MEM             = 2'b00;
        dmem_ack           = 1'b0;
        dmem_rdata         = '0;
        exp_wb   = 2'b00;
        exp_rd   = 5'd0;
        exp_data = '0;
        exp_alu  = '0;
        exp_err  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst req",   {31'd0, dmem_req}, 32'd0);
        check("rst stall", {31'd0, stall},    32'd0);
        check_wb_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        run_instr(32'h10, 32'h0, 5'd5, 3'b010, 2'b11, 0, 32'hDEADBEEF);
        run_instr(32'h20, 32'h12345678, 5'd3, 3'b001, 2'b00, 3, 32'h0);
        run_instr(32'h44, 32'h0, 5'd7, 3'b010, 2'b11, 2, 32'hCAFEF00D);
        run_instr(32'h13, 32'h0, 5'd8, 3'b010, 2'b11, 0, 32'h0);
        run_instr(32'h7, 32'h0, 5'd9, 3'b000, 2'b10, 0, 32'h0);
        run_instr(32'h30, 32'hA5A5A5A5, 5'd4, 3'b011, 2'b11, 1, 32'h0);

        // Randomised mix of loads, stores, ALU ops and misaligned accesses
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_instr(a, $urandom, 5'($urandom), 3'($urandom), 2'($urandom),
                      int'($urandom_range(0, 4)), $urandom);
        end

        // Reset while a load is waiting on the bus
        @(negedge clk);
        res_mem  = 32'h100;
        m_MEM    = 3'b010;
        wb_MEM   = 2'b11;
        dmem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("busy req",   {31'd0, dmem_req}, 32'd1);
        check("busy stall", {31'd0, stall},    32'd1);
        rst_n = 1'b0;
        #1;
        check("arst req",   {31'd0, dmem_req}, 32'd0);
        check("arst stall", {31'd0, stall},    32'd0);
        exp_wb   = 2'b00;
        exp_rd   = 5'd0;
        exp_data = '0;
        exp_alu  = '0;
        exp_err  = 1'b0;
        check_wb_regs("arst");
        m_MEM = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst req", {31'd0, dmem_req}, 32'd0);
        run_instr(32'h7, 32'h0, 5'd9, 3'b000, 2'b10, 0, 32'h0);
        run_instr(32'h10, 32'h0, 5'd5, 3'b010, 2'b11, 0, 32'h01020304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
